// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key IDs and decoder states for the PS/2 scan sequencer.
package ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int NUM_KEYS = 5;
  localparam int EVT_W    = 4;

  typedef enum logic [2:0] {
    KEY_UP    = 3'd0,
    KEY_DOWN  = 3'd1,
    KEY_LEFT  = 3'd2,
    KEY_RIGHT = 3'd3,
    KEY_SPACE = 3'd4
  } key_id_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } dec_state_e;

  typedef struct packed {
    logic    hit;
    key_id_e key;
  } arrow_t;

  // Extended (E0-prefixed) arrow second bytes map onto key IDs 0..3.
  function automatic arrow_t arrow_lookup(input logic [7:0] c);
    arrow_t a;
    a.hit = 1'b1;
    a.key = KEY_UP;
    case (c)
      SC_UP:    a.key = KEY_UP;
      SC_DOWN:  a.key = KEY_DOWN;
      SC_LEFT:  a.key = KEY_LEFT;
      SC_RIGHT: a.key = KEY_RIGHT;
      default:  a.hit = 1'b0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small valid/ready event FIFO; read data is forced to zero while empty.
module ps2_event_fifo #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign rd_valid = (cnt_q != '0);
  assign do_pop   = rd_valid & rd_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts.
  assign wr_ready = (cnt_q != CNT_W'(FIFO_DEPTH)) | do_pop;
  assign do_push  = wr_valid & wr_ready;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code decoder for arrows/space feeding an event FIFO and a live key bitmap.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat make events.
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 500000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                code_valid,
  input  logic [7:0]          code,
  input  logic                code_error,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2:0]          evt_key,
  output logic                evt_break,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                overflow
);

  localparam int             TO_W    = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  dec_state_e          state_q, state_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic                overflow_q, overflow_d;

  arrow_t              arrow;
  logic                emit;
  key_id_e             emit_key;
  logic                emit_brk;
  logic                push;
  logic                wr_ready;
  logic [EVT_W-1:0]    wr_data;
  logic [EVT_W-1:0]    rd_data;

  assign arrow = arrow_lookup(code);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    emit_key = KEY_UP;
    emit_brk = 1'b0;
    if (code_error) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (code_valid) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      unique case (state_q)
        ST_IDLE: begin
          if (code == SC_E0)         state_d = ST_E0;
          else if (code == SC_F0)    state_d = ST_F0;
          else if (code == SC_SPACE) begin
            emit     = 1'b1;
            emit_key = KEY_SPACE;
          end
        end
        ST_E0: begin
          if (code == SC_F0)  state_d = ST_E0F0;
          else if (arrow.hit) begin
            emit     = 1'b1;
            emit_key = arrow.key;
          end
        end
        ST_F0: begin
          if (code == SC_SPACE) begin
            emit     = 1'b1;
            emit_key = KEY_SPACE;
            emit_brk = 1'b1;
          end
        end
        ST_E0F0: begin
          if (arrow.hit) begin
            emit     = 1'b1;
            emit_key = arrow.key;
            emit_brk = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is abandoned so a lost byte cannot poison the next key.
      if (cnt_q >= TO_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  always_comb begin
    held_d = held_q;
    push   = emit;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (emit && !emit_brk && held_q[emit_key]) push = 1'b0;
`endif
    if (push) held_d[emit_key] = ~emit_brk;
    overflow_d = overflow_q | (push & ~wr_ready);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      held_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_data = {emit_brk, emit_key};

  ps2_event_fifo #(
    .DATA_W    (EVT_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_valid(push),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .rd_valid(evt_valid),
    .rd_data (rd_data),
    .rd_ready(evt_ready)
  );

  assign evt_key   = rd_data[2:0];
  assign evt_break = rd_data[3];
  assign key_held  = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed plus randomized bench for ps2_scan_sequencer against a byte-sequence reference model.
module tb_ps2_scan_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       code_error = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic       evt_break;
  logic [4:0] key_held;
  logic       overflow;

  ps2_scan_sequencer #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .code_valid(code_valid), .code(code), .code_error(code_error),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key), .evt_break(evt_break),
    .key_held(key_held), .overflow(overflow)
  );

  always #10 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state: pending byte sequence, expected event queue, bitmap, sticky flag.
  logic [7:0] seq[$];
  logic [3:0] exp_q[$];
  logic [4:0] m_held = '0;
  logic       m_ovf  = 1'b0;
  int         cyc = 0;
  int         last_acc = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int arrow_id(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  // Match the whole pending sequence against the complete key sequences.
  task automatic decode(output logic em, output logic [2:0] k, output logic b);
    int n;
    n = seq.size();
    em = 1'b0; k = 3'd0; b = 1'b0;
    if (n == 1 && seq[0] == 8'h29) begin
      em = 1'b1; k = 3'd4;
    end else if (n == 2 && seq[0] == 8'hF0 && seq[1] == 8'h29) begin
      em = 1'b1; k = 3'd4; b = 1'b1;
    end else if (n == 2 && seq[0] == 8'hE0 && arrow_id(seq[1]) >= 0) begin
      em = 1'b1; k = 3'(arrow_id(seq[1]));
    end else if (n == 3 && seq[0] == 8'hE0 && seq[1] == 8'hF0 && arrow_id(seq[2]) >= 0) begin
      em = 1'b1; k = 3'(arrow_id(seq[2])); b = 1'b1;
    end
    if (em) seq.delete();
    else if (!((n == 1 && (seq[0] == 8'hE0 || seq[0] == 8'hF0)) ||
               (n == 2 && seq[0] == 8'hE0 && seq[1] == 8'hF0))) seq.delete();
  endtask

  task automatic model_edge(input logic v, input logic [7:0] c, input logic e, input logic r);
    logic do_pop, em, b, skip;
    logic [2:0] k;
    do_pop = (exp_q.size() != 0) && r;
    em = 1'b0; k = 3'd0; b = 1'b0;
    if (e) seq.delete();
    else if (v) begin
      if (seq.size() != 0 && (cyc + 1 - last_acc) > TO) seq.delete();
      last_acc = cyc + 1;
      seq.push_back(c);
      decode(em, k, b);
    end
    if (do_pop) void'(exp_q.pop_front());
    if (em) begin
      skip = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      skip = !b && m_held[k];
`endif
      if (!skip) begin
        m_held[k] = !b;
        if (exp_q.size() < DEPTH) exp_q.push_back({b, k});
        else m_ovf = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("evt_valid", evt_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("evt_key", evt_key, exp_q[0][2:0]);
      chk("evt_break", evt_break, exp_q[0][3]);
    end
    chk("key_held", key_held, m_held);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic e, input logic r);
    code_valid = v; code = c; code_error = e; evt_ready = r;
    model_edge(v, c, e, r);
    @(posedge CLK); #1;
    code_valid = 1'b0; code_error = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_key"}, evt_key, 0);
    chk({tag, "_break"}, evt_break, 0);
    chk({tag, "_held"}, key_held, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    code_valid = 1'b0; code_error = 1'b0;
    RST = 1'b1;
    #1 check_zero("rst_during");
    seq.delete(); exp_q.delete(); m_held = '0; m_ovf = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1 check_zero("rst_after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [8];
    int n_seen;
    pool = '{8'hE0, 8'hF0, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};

    #1 check_zero("por");
    @(negedge CLK); RST = 1'b0;
    #1 check_zero("por_release");

    // Space make then break.
    step(1, 8'h29, 0, 0);
    chk("space_make_held", key_held[4], 1);
    step(1, 8'hF0, 0, 1);
    step(1, 8'h29, 0, 1);
    chk("space_break_held", key_held[4], 0);
    idle(3, 1);

    // UP make/break, bare 75 ignored.
    step(1, 8'hE0, 0, 1); step(1, 8'h75, 0, 0);
    chk("up_make_key", evt_key, 0);
    step(1, 8'hE0, 0, 1); step(1, 8'hF0, 0, 0); step(1, 8'h75, 0, 0);
    idle(3, 1);
    step(1, 8'h75, 0, 1);
    chk("bare75_none", evt_valid, 0);
    step(1, 8'hE0, 0, 1); step(1, 8'h29, 0, 1);
    chk("e0_29_none", evt_valid, 0);

    // Overflow with five makes, then full+push+pop.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'h29, 0, 0);
    chk("ovf_set", overflow, 1);
    idle(6, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h29, 0, 0);
    step(1, 8'h29, 0, 1);
    chk("ovf_pushpop", overflow, 0);
    idle(6, 1);

    // Prefix timeout, near-timeout acceptance, error abort.
    step(1, 8'hE0, 0, 1); idle(TO, 1); step(1, 8'h74, 0, 1);
    chk("timeout_none", evt_valid, 0);
    step(1, 8'hE0, 0, 1); idle(5, 1); step(1, 8'h74, 0, 0);
    chk("notimeout_key", evt_key, 3);
    idle(2, 1);
    step(1, 8'hE0, 0, 1); step(0, 8'h00, 1, 1); step(1, 8'h74, 0, 1);
    chk("error_none", evt_valid, 0);
    step(1, 8'hE0, 0, 1); step(1, 8'hF0, 1, 1); step(1, 8'h74, 0, 1);
    idle(2, 1);

    // Typematic repeats.
    do_reset();
    for (int i = 0; i < 3; i++) begin step(1, 8'hE0, 0, 0); step(1, 8'h6B, 0, 0); end
    n_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (evt_valid) n_seen++;
      step(0, 8'h00, 0, 1);
    end
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_count", 8'(n_seen), 1);
`else
    chk("typematic_count", 8'(n_seen), 3);
`endif

    // Reset mid-sequence.
    step(1, 8'hE0, 0, 1); step(1, 8'hF0, 0, 1);
    do_reset();
    step(1, 8'h72, 0, 1);
    chk("rst_mid_none", evt_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c;
      c = pool[$urandom_range(0, 7)];
      if (c == 8'h00) c = 8'($urandom);
      if ($urandom_range(0, 99) < 3) idle($urandom_range(15, 25), $urandom_range(0, 1));
      else step($urandom_range(0, 99) < 45, c, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 55);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
